// File: rtl/uart_mem_dump_pkg.sv
// Shared definitions for the UART memory dump path and its receive-side sibling:
// FSM encoding, 8N1 frame constants and the default 115200-baud divisor at 50 MHz.
package uart_mem_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_TX,
    ST_FINISH
  } dump_state_t;

  typedef struct packed {
    dump_state_t state;
    logic [1:0]  byte_idx;
    logic        tx_busy;
  } dump_dbg_t;

  localparam logic START_BIT            = 1'b0;
  localparam logic STOP_BIT             = 1'b1;
  localparam int   DATA_BITS            = 8;
  localparam int   FRAME_BITS           = 10;
  localparam int   DEFAULT_CLKS_PER_BIT = 434;

  // Frame is shifted out from bit 0: start bit, data LSB first, stop bit.
  function automatic logic [FRAME_BITS-1:0] frame_of(input logic [DATA_BITS-1:0] b);
    return {STOP_BIT, b, START_BIT};
  endfunction

endpackage

// File: rtl/uart_mem_dump_if.sv
// Host/RAM/UART-side signal bundle of the memory dump block.
// start is a one-cycle request taken only while busy=0; rd_en strobes one read per word and
// rd_data answers two cycles later; done pulses once per accepted request, as busy drops.
interface uart_mem_dump_if #(
  parameter int ADDR_W = 9
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [31:0]       rd_data;
  logic              UART_TXD;
  logic              busy;
  logic              done;

  modport master (
    output start, base_addr, word_count, rd_data,
    input  rd_addr, rd_en, UART_TXD, busy, done
  );

  modport slave (
    input  start, base_addr, word_count, rd_data,
    output rd_addr, rd_en, UART_TXD, busy, done
  );
endinterface

// File: rtl/uart_mem_dump_tx_serializer.sv
// 8N1 byte serializer: bit-period counter plus a 10-bit frame shift register.
// tx_done marks the last clock of the stop bit; tx_start while busy is ignored.
module uart_mem_dump_tx_serializer
  import uart_mem_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       UART_TXD,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

  logic [CNT_W-1:0]      r_cnt;
  logic [3:0]            r_bit;
  logic [FRAME_BITS-1:0] r_shift;
  logic                  r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '1;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_bit   <= '0;
    end else if (!r_busy) begin
      if (tx_start) begin
        r_shift <= frame_of(tx_byte);
        r_busy  <= 1'b1;
        r_cnt   <= '0;
        r_bit   <= '0;
      end
    end else if (r_cnt == CNT_LAST) begin
      // Refill with idle-high so the line rests at 1 once the stop bit ends.
      r_cnt   <= '0;
      r_shift <= {STOP_BIT, r_shift[FRAME_BITS-1:1]};
      if (r_bit == BIT_LAST) r_busy <= 1'b0;
      else                   r_bit  <= r_bit + 4'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign UART_TXD = r_shift[0];
  assign tx_busy  = r_busy;
  assign tx_done  = r_busy && (r_bit == BIT_LAST) && (r_cnt == CNT_LAST);

endmodule

// File: rtl/uart_mem_dump.sv
// Reads word_count words from base_addr and streams them out over UART, LSB byte first.
// Outputs are registered; each one is set on the transition into the state that owns it.
module uart_mem_dump
  import uart_mem_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int ADDR_W       = 9
) (
  input  logic             clk,
  input  logic             rst,
  uart_mem_dump_if.slave   bus,
  output dump_dbg_t        o_dbg
);

  dump_state_t       r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W:0]   r_remaining;
  logic [31:0]       r_word;
  logic [1:0]        r_byte_idx;
  logic [7:0]        r_tx_byte;
  logic              r_rd_en;
  logic              r_tx_start;
  logic              r_busy;
  logic              r_done;

  logic              w_tx_done;
  logic              w_tx_busy;
  logic              w_txd;
  logic [1:0]        w_next_idx;
  logic [ADDR_W:0]   w_rem_dec;
  logic [ADDR_W-1:0] w_addr_inc;

  assign w_next_idx = r_byte_idx + 2'd1;
  assign w_rem_dec  = r_remaining - 1'b1;
  assign w_addr_inc = r_addr + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_rd_addr   <= '0;
      r_remaining <= '0;
      r_word      <= '0;
      r_byte_idx  <= '0;
      r_tx_byte   <= '0;
      r_rd_en     <= 1'b0;
      r_tx_start  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_rd_en    <= 1'b0;
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_addr      <= bus.base_addr;
            r_remaining <= bus.word_count;
            r_busy      <= 1'b1;
            if (bus.word_count == '0) begin
              r_state <= ST_FINISH;
            end else begin
              r_state   <= ST_READ;
              r_rd_en   <= 1'b1;
              r_rd_addr <= bus.base_addr;
            end
          end
        end
        ST_READ: r_state <= ST_WAIT;
        ST_WAIT: r_state <= ST_LOAD;
        ST_LOAD: begin
          r_word     <= bus.rd_data;
          r_byte_idx <= '0;
          r_tx_byte  <= bus.rd_data[7:0];
          r_tx_start <= 1'b1;
          r_state    <= ST_SEND;
        end
        ST_SEND: r_state <= ST_WAIT_TX;
        ST_WAIT_TX: begin
          if (w_tx_done) begin
            if (r_byte_idx != 2'd3) begin
              r_byte_idx <= w_next_idx;
              r_tx_byte  <= r_word[{w_next_idx, 3'b000} +: 8];
              r_tx_start <= 1'b1;
              r_state    <= ST_SEND;
            end else begin
              // Address wraps naturally at 2^ADDR_W.
              r_remaining <= w_rem_dec;
              r_addr      <= w_addr_inc;
              if (w_rem_dec != '0) begin
                r_state   <= ST_READ;
                r_rd_en   <= 1'b1;
                r_rd_addr <= w_addr_inc;
              end else begin
                r_state <= ST_FINISH;
              end
            end
          end
        end
        ST_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  uart_mem_dump_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_serializer (
    .clk      (clk),
    .rst      (rst),
    .tx_start (r_tx_start),
    .tx_byte  (r_tx_byte),
    .UART_TXD (w_txd),
    .tx_busy  (w_tx_busy),
    .tx_done  (w_tx_done)
  );

  assign bus.rd_addr  = r_rd_addr;
  assign bus.rd_en    = r_rd_en;
  assign bus.UART_TXD = w_txd;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

  assign o_dbg.state    = r_state;
  assign o_dbg.byte_idx = r_byte_idx;
  assign o_dbg.tx_busy  = w_tx_busy;

endmodule
